// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the instruction/data RAM port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } mem_size_t;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    // Byte-lane mask for an access size; the illegal size maps to a full
    // mask because such a request never writes anyway.
    function automatic logic [3:0] size_to_mask(input mem_size_t size);
        case (size)
            SZ_BYTE: size_to_mask = MASK_BYTE;
            SZ_HALF: size_to_mask = MASK_HALF;
            default: size_to_mask = MASK_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_fmt.sv
// Load-data formatter: sign- or zero-extends a right-justified RAM word.
module mem_load_fmt
    import mem_arb_pkg::*;
(
    input  mem_size_t   size_i,
    input  logic        signed_i,
    input  logic [31:0] raw_i,
    output logic [31:0] data_o
);

    // Extend from bit 7 or bit 15 depending on access size.
    always_comb begin
        data_o = raw_i;
        case (size_i)
            SZ_BYTE: data_o = {{24{signed_i & raw_i[7]}}, raw_i[7:0]};
            SZ_HALF: data_o = {{16{signed_i & raw_i[15]}}, raw_i[15:0]};
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shared RAM port arbiter: data over fetch with a starvation guard,
// alignment checking and one-cycle registered responses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 13,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rsp_data,
    input  logic              dm_req_valid,
    output logic              dm_req_ready,
    input  logic              dm_req_we,
    input  logic [1:0]        dm_req_size,
    input  logic              dm_req_signed,
    input  logic [ADDR_W-1:0] dm_req_addr,
    input  logic [31:0]       dm_req_wdata,
    output logic              dm_rsp_valid,
    output logic [31:0]       dm_rsp_data,
    output logic              dm_rsp_err,
    output logic              mem_we,
    output logic [3:0]        mem_mask,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    mem_size_t   dm_size;
    logic        if_gnt, dm_gnt, dm_err;
    logic [31:0] load_data;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        if_rsp_valid_q, if_rsp_valid_d;
    logic [31:0] if_rsp_data_q, if_rsp_data_d;
    logic        dm_rsp_valid_q, dm_rsp_valid_d;
    logic [31:0] dm_rsp_data_q, dm_rsp_data_d;
    logic        dm_rsp_err_q, dm_rsp_err_d;

    assign dm_size = mem_size_t'(dm_req_size);

    // Grant: data has priority unless fetch has waited STARVE_MAX cycles.
    always_comb begin
        if_gnt = if_req_valid && (!dm_req_valid || (starve_cnt_q == STARVE_LIM));
        dm_gnt = dm_req_valid && !if_gnt;
    end

    // Misaligned halves/words and the illegal size are rejected.
    always_comb begin
        dm_err = 1'b0;
        case (dm_size)
            SZ_BYTE: dm_err = 1'b0;
            SZ_HALF: dm_err = dm_req_addr[0];
            SZ_WORD: dm_err = (dm_req_addr[1:0] != 2'b00);
            default: dm_err = 1'b1;
        endcase
    end

    // RAM port drive; rejected data requests still steer the read port but
    // never write.
    always_comb begin
        mem_we    = 1'b0;
        mem_mask  = MASK_WORD;
        mem_waddr = '0;
        mem_raddr = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_raddr = if_req_addr;
        end else if (dm_gnt) begin
            mem_raddr = dm_req_addr;
            mem_waddr = dm_req_addr;
            mem_mask  = size_to_mask(dm_size);
            mem_wdata = dm_req_wdata;
            mem_we    = dm_req_we && !dm_err;
        end
    end

    mem_load_fmt u_load_fmt (
        .size_i   (dm_size),
        .signed_i (dm_req_signed),
        .raw_i    (mem_rdata),
        .data_o   (load_data)
    );

    // Next-state: starvation counter and the responses for this cycle's grant.
    always_comb begin
        starve_cnt_d = '0;
        if (if_req_valid && !if_gnt)
            starve_cnt_d = (starve_cnt_q == 4'hF) ? starve_cnt_q : starve_cnt_q + 4'd1;
        if_rsp_valid_d = if_gnt;
        if_rsp_data_d  = if_gnt ? mem_rdata : 32'd0;
        dm_rsp_valid_d = dm_gnt;
        dm_rsp_err_d   = dm_gnt && dm_err;
        dm_rsp_data_d  = (dm_gnt && !dm_err && !dm_req_we) ? load_data : 32'd0;
    end

    // State and response registers; reset drops any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q   <= '0;
            if_rsp_valid_q <= 1'b0;
            if_rsp_data_q  <= '0;
            dm_rsp_valid_q <= 1'b0;
            dm_rsp_data_q  <= '0;
            dm_rsp_err_q   <= 1'b0;
        end else begin
            starve_cnt_q   <= starve_cnt_d;
            if_rsp_valid_q <= if_rsp_valid_d;
            if_rsp_data_q  <= if_rsp_data_d;
            dm_rsp_valid_q <= dm_rsp_valid_d;
            dm_rsp_data_q  <= dm_rsp_data_d;
            dm_rsp_err_q   <= dm_rsp_err_d;
        end
    end

    assign if_req_ready = if_gnt;
    assign dm_req_ready = dm_gnt;
    assign if_rsp_valid = if_rsp_valid_q;
    assign if_rsp_data  = if_rsp_data_q;
    assign dm_rsp_valid = dm_rsp_valid_q;
    assign dm_rsp_data  = dm_rsp_data_q;
    assign dm_rsp_err   = dm_rsp_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a byte-addressed RAM model.
module tb_mem_port_arbiter;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req_valid, if_req_ready;
    logic [AW-1:0] if_req_addr;
    logic          if_rsp_valid;
    logic [31:0]   if_rsp_data;
    logic          dm_req_valid, dm_req_ready, dm_req_we, dm_req_signed;
    logic [1:0]    dm_req_size;
    logic [AW-1:0] dm_req_addr;
    logic [31:0]   dm_req_wdata;
    logic          dm_rsp_valid, dm_rsp_err;
    logic [31:0]   dm_rsp_data;
    logic          mem_we;
    logic [3:0]    mem_mask;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [31:0]   mem_wdata, mem_rdata;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } dm_exp_t;

    dm_exp_t     dm_q[$];
    logic [31:0] if_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  ram [0:(1<<AW)-1];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_we(dm_req_we),
        .dm_req_size(dm_req_size), .dm_req_signed(dm_req_signed), .dm_req_addr(dm_req_addr),
        .dm_req_wdata(dm_req_wdata), .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data),
        .dm_rsp_err(dm_rsp_err), .mem_we(mem_we), .mem_mask(mem_mask),
        .mem_waddr(mem_waddr), .mem_raddr(mem_raddr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // RAM model: store commits at the falling edge; read is masked and right-justified.
    always @(negedge clk) begin
        if (mem_we)
            for (int i = 0; i < 4; i++)
                if (mem_mask[i]) ram[mem_waddr + AW'(i)] <= mem_wdata[8*i +: 8];
    end

    always_comb begin
        mem_rdata = 32'd0;
        for (int i = 0; i < 4; i++)
            mem_rdata[8*i +: 8] = mem_mask[i] ? ram[mem_raddr + AW'(i)] : 8'h00;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else
            $display("ok   %s: %h", name, act);
    endtask

    // Monitor: pop the scoreboard whenever a response is presented.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (dm_rsp_valid) begin
                if (dm_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL dm_unexpected: got data %h err %b expected no response", dm_rsp_data, dm_rsp_err);
                end else begin
                    dm_exp_t e;
                    e = dm_q.pop_front();
                    check("dm_rsp", {dm_rsp_data[30:0], dm_rsp_err} ^ {31'd0, 1'b0} | 32'd0,
                          {e.d[30:0], e.e});
                    check("dm_rsp_msb", {31'd0, dm_rsp_data[31]}, {31'd0, e.d[31]});
                end
            end
            if (if_rsp_valid) begin
                if (if_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL if_unexpected: got %h expected no response", if_rsp_data);
                end else begin
                    logic [31:0] ie;
                    ie = if_q.pop_front();
                    check("if_rsp", if_rsp_data, ie);
                end
            end
        end
    end

    // Issue one data request, wait for acceptance, and record its expected response.
    task automatic dm_op(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [AW-1:0] a, input logic [31:0] wd,
                         input logic [31:0] ed, input logic ee);
        bit got;
        dm_req_valid = 1'b1; dm_req_we = we; dm_req_size = sz;
        dm_req_signed = sg; dm_req_addr = a; dm_req_wdata = wd;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = dm_req_ready;
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL dm_accept_timeout: addr %h never accepted", a);
        end else begin
            if (ee) check("err_no_write", {31'd0, mem_we}, 32'd0);
            dm_q.push_back('{d: ed, e: ee});
        end
        @(posedge clk); #1;
        dm_req_valid = 1'b0;
    endtask

    task automatic if_op(input logic [AW-1:0] a, input logic [31:0] ed);
        bit got;
        if_req_valid = 1'b1; if_req_addr = a;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = if_req_ready;
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL if_accept_timeout: addr %h never accepted", a);
        end else
            if_q.push_back(ed);
        @(posedge clk); #1;
        if_req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) ram[i] = 8'h00;
        rst_n = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 13'h0010;
        dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_size = 2'd2;
        dm_req_signed = 1'b0; dm_req_addr = 13'h0010; dm_req_wdata = 32'd0;

        // Reset held with both requesters active.
        repeat (3) @(negedge clk);
        check("rst_if_rsp_valid", {31'd0, if_rsp_valid}, 32'd0);
        check("rst_dm_rsp_valid", {31'd0, dm_rsp_valid}, 32'd0);
        check("rst_dm_rsp_err", {31'd0, dm_rsp_err}, 32'd0);
        check("rst_starve_cnt", {28'd0, dut.starve_cnt_q}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("first_grant", {30'd0, if_req_ready, dm_req_ready}, 32'd1);
        dm_q.push_back('{d: 32'd0, e: 1'b0});
        @(posedge clk); #1;
        if_req_valid = 1'b0; dm_req_valid = 1'b0;

        // Store/load and sign extension.
        dm_op(1'b1, 2'd2, 1'b0, 13'h0010, 32'hDEADBEEF, 32'd0, 1'b0);
        dm_op(1'b0, 2'd2, 1'b0, 13'h0010, 32'd0, 32'hDEADBEEF, 1'b0);
        dm_op(1'b1, 2'd0, 1'b0, 13'h0021, 32'h00000080, 32'd0, 1'b0);
        dm_op(1'b0, 2'd0, 1'b1, 13'h0021, 32'd0, 32'hFFFFFF80, 1'b0);
        dm_op(1'b0, 2'd0, 1'b0, 13'h0021, 32'd0, 32'h00000080, 1'b0);
        dm_op(1'b1, 2'd1, 1'b0, 13'h0022, 32'h00008001, 32'd0, 1'b0);
        dm_op(1'b0, 2'd1, 1'b1, 13'h0022, 32'd0, 32'hFFFF8001, 1'b0);
        dm_op(1'b0, 2'd1, 1'b0, 13'h0022, 32'd0, 32'h00008001, 1'b0);

        // Rejected requests, then confirm the RAM is untouched.
        dm_op(1'b0, 2'd2, 1'b0, 13'h0013, 32'd0, 32'd0, 1'b1);
        dm_op(1'b1, 2'd1, 1'b0, 13'h0005, 32'h00001234, 32'd0, 1'b1);
        dm_op(1'b1, 2'd3, 1'b0, 13'h0010, 32'h00000000, 32'd0, 1'b1);
        dm_op(1'b0, 2'd2, 1'b0, 13'h0010, 32'd0, 32'hDEADBEEF, 1'b0);
        dm_op(1'b0, 2'd1, 1'b0, 13'h0004, 32'd0, 32'h00000000, 1'b0);
        dm_op(1'b0, 2'd2, 1'b0, 13'h0020, 32'd0, 32'h80018000, 1'b0);
        if_op(13'h0010, 32'hDEADBEEF);

        // Continuous contention: four data grants, then one fetch grant.
        if_req_valid = 1'b1; if_req_addr = 13'h0010;
        dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_size = 2'd2;
        dm_req_signed = 1'b0; dm_req_addr = 13'h0020;
        for (int k = 0; k < 15; k++) begin
            logic exp_if;
            exp_if = ((k % 5) == 4);
            @(negedge clk);
            check($sformatf("starve_grant_%0d", k), {30'd0, if_req_ready, dm_req_ready},
                  {30'd0, exp_if, ~exp_if});
            if (if_req_ready) if_q.push_back(32'hDEADBEEF);
            if (dm_req_ready) dm_q.push_back('{d: 32'h80018000, e: 1'b0});
            @(posedge clk); #1;
        end
        if_req_valid = 1'b0; dm_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset lands before the accepting edge: the response must never appear.
        dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_size = 2'd2; dm_req_addr = 13'h0010;
        @(negedge clk);
        check("midrst_ready", {31'd0, dm_req_ready}, 32'd1);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        dm_req_valid = 1'b0;
        @(negedge clk);
        check("midrst_no_rsp", {31'd0, dm_rsp_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dm_op(1'b0, 2'd2, 1'b0, 13'h0010, 32'd0, 32'hDEADBEEF, 1'b0);

        repeat (3) @(negedge clk);
        check("dm_q_drained", dm_q.size(), 32'd0);
        check("if_q_drained", if_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
